// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = inA - inB - bIn, one bit
// per clock, LSB first. A start/done handshake frames each operation; the
// result and its flags hold until the next operation completes.
module serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             bIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bOut,
    output logic             ovf,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;        // minuend, shifted right each RUN cycle
    logic [WIDTH-1:0] r_b;        // subtrahend, shifted right each RUN cycle
    logic             r_a_msb;    // sign bits kept for the overflow flag,
    logic             r_b_msb;    // since the shift registers lose them
    logic             r_br;       // running borrow
    logic [CNT_W-1:0] r_cnt;      // index of the bit being processed
    logic [WIDTH-1:0] r_acc;      // partial difference, filled from the MSB

    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_accept;
    logic             w_last;
    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_acc_next;

    // start is only honoured when no operation is in flight
    assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

    // single-bit difference/borrow cell
    assign w_d        = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_acc_next = {w_d, r_acc[WIDTH-1:1]};

    // State register with synchronous reset
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: IDLE -> RUN on start, RUN -> DONE after the last bit,
    // DONE -> RUN (back-to-back) or IDLE
    // NOTE: the default assignment first keeps this purely combinational;
    // a path that leaves w_state_next unassigned would infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand load, bit-serial datapath and result/flag capture
    // NOTE: datapath registers are reset as well so outputs are defined
    // immediately after reset rather than carrying stale or X values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= inA;
            r_b     <= inB;
            r_a_msb <= inA[WIDTH-1];
            r_b_msb <= inB[WIDTH-1];
            r_br    <= bIn;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_br  <= w_br_next;
            r_cnt <= r_cnt + CNT_W'(1);
            r_acc <= w_acc_next;
            if (w_last) begin
                r_diff <= w_acc_next;
                r_bout <= w_br_next;
                r_ovf  <= (r_a_msb != r_b_msb) && (w_acc_next[WIDTH-1] != r_a_msb);
                r_zero <= ~|w_acc_next;
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign diff = r_diff;
    assign bOut = r_bout;
    assign ovf  = r_ovf;
    assign zero = r_zero;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (WIDTH = 16).
module tb_serial_subtractor;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] inA;
    logic [15:0] inB;
    logic        bIn;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        bOut;
    logic        ovf;
    logic        zero;

    int          n_vec;
    int          n_err;
    logic [15:0] prev_diff;

    serial_subtractor #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .inA   (inA),
        .inB   (inB),
        .bIn   (bIn),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bOut  (bOut),
        .ovf   (ovf),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one rising edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // wait for done (bounded); optionally pulse start with junk operands so
    // that it is sampled at accept-edge +3 and +8
    task automatic wait_done(input bit glitch, input logic [15:0] a, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (glitch && (cyc == 2 || cyc == 7)) begin
                start = 1'b1;
                inA   = ~a;
                inB   = a;
                bIn   = 1'b1;
            end else if (glitch && (cyc == 3 || cyc == 8)) begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic bin, input logic [15:0] exp_diff,
                          input logic [2:0] exp_flags, input bit glitch);
        int cyc;
        inA   = a;
        inB   = b;
        bIn   = bin;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_hold"}, {16'd0, diff}, {16'd0, prev_diff});
        wait_done(glitch, a, cyc);
        check({tag, "_latency"}, cyc, 32'd16);
        check({tag, "_diff"}, {16'd0, diff}, {16'd0, exp_diff});
        check({tag, "_flags"}, {29'd0, bOut, ovf, zero}, {29'd0, exp_flags});
        prev_diff = exp_diff;
        tick();
        check({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        int cyc;
        int n_done;
        n_vec     = 0;
        n_err     = 0;
        prev_diff = 16'h0000;
        rst_n     = 1'b0;
        start     = 1'b0;
        inA       = '0;
        inB       = '0;
        bIn       = 1'b0;

        // reset, then idle with start low
        tick();
        tick();
        check("rst_ctl", {30'd0, busy, done}, 32'd0);
        check("rst_out", {13'd0, diff, bOut, ovf, zero}, 32'd0);
        rst_n  = 1'b1;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy || done) n_done++;
        end
        check("idle_quiet", n_done, 32'd0);
        check("idle_out", {13'd0, diff, bOut, ovf, zero}, 32'd0);

        // directed vectors: flags are {bOut, ovf, zero}
        run_op("basic",   16'h0005, 16'h0003, 1'b0, 16'h0002, 3'b000, 1'b0);
        run_op("wrap",    16'h0000, 16'h0001, 1'b0, 16'hFFFF, 3'b100, 1'b0);
        run_op("eq",      16'h0005, 16'h0005, 1'b0, 16'h0000, 3'b001, 1'b0);
        run_op("ovf_neg", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 3'b010, 1'b0);
        run_op("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 3'b110, 1'b0);
        run_op("bin",     16'h0010, 16'h0001, 1'b1, 16'h000E, 3'b000, 1'b0);
        run_op("ignore",  16'h0100, 16'h0001, 1'b0, 16'h00FF, 3'b000, 1'b1);

        // back-to-back: start held during DONE
        inA   = 16'h0020;
        inB   = 16'h0010;
        bIn   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1'b0, 16'h0020, cyc);
        check("b2b_first_lat", cyc, 32'd16);
        check("b2b_first_diff", {16'd0, diff}, 32'h0010);
        inA   = 16'h0009;
        inB   = 16'h0004;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_restart", {30'd0, busy, done}, 32'd2);
        wait_done(1'b0, 16'h0009, cyc);
        check("b2b_spacing", cyc + 1, 32'd17);
        check("b2b_diff", {16'd0, diff}, 32'h0005);
        tick();

        // reset mid-operation, asserted so it is sampled at accept-edge +7
        inA   = 16'h1234;
        inB   = 16'h0034;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_ctl", {30'd0, busy, done}, 32'd0);
        check("midrst_out", {13'd0, diff, bOut, ovf, zero}, 32'd0);
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) n_done++;
        end
        check("midrst_nodone", n_done, 32'd0);
        prev_diff = 16'h0000;
        run_op("fresh", 16'h1234, 16'h0034, 1'b0, 16'h1200, 3'b000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor: computes inA - inB - bIn, one bit per clock, LSB first.
- Datapath is a single-bit difference/borrow cell plus a borrow flip-flop and shift registers.
- Sits beside the ripple adders in the ALU as a low-area multi-cycle subtract unit.
- Driven by a start/done handshake from the execute-stage controller.

Parameters:
- WIDTH, 16, operand and result width in bits (>= 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only when state is IDLE or DONE.
- inA  input  WIDTH  minuend; latched on accepted start.
- inB  input  WIDTH  subtrahend; latched on accepted start.
- bIn  input  1  borrow-in; latched on accepted start.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  difference; held until next accepted start.
- bOut  output  1  final borrow (1 when unsigned inA < inB + bIn).
- ovf  output  1  signed overflow.
- zero  output  1  diff == 0.

Behaviour:
- Reset: rst_n low at a rising edge forces the following, regardless of current state:
  - state = IDLE.
  - busy = 0, done = 0, diff = 0, bOut = 0, ovf = 0, zero = 0.
  - Internal bit counter = 0; borrow flop = 0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - start = 1 latches inA, inB and bIn; borrow flop is loaded with bIn; counter = 0; next state is RUN.
  - start = 0 stays in IDLE.
- RUN: each edge processes bit i = counter:
  - d_i = a_i ^ b_i ^ br.
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - d_i is shifted into the result register from the MSB side; the operand registers shift right by one.
  - Counter increments.
  - The edge that processes bit WIDTH-1 moves state to DONE.
  - start is ignored throughout RUN; latched operands are unaffected by input changes.
- DONE (exactly one cycle):
  - done = 1 and busy = 0.
  - diff, bOut, ovf and zero are updated on the same edge that enters DONE.
  - Next state is RUN if start = 1 (new operands accepted, back-to-back operation); otherwise IDLE.
- Latency: with start accepted at edge N, busy is high after edges N .. N+WIDTH-1, and done is high after edge N+WIDTH.
  - The operation takes WIDTH cycles in RUN.
  - Back-to-back throughput is one result per WIDTH+1 cycles.
- Output flags:
  - bOut = final borrow flop value.
  - ovf = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]), where A and B are the latched operands.
  - zero = ~|diff.
- Result hold: diff, bOut, ovf and zero hold their values through IDLE and through the RUN of the next operation. They change only on the edge entering DONE, or on reset.
- Reset mid-operation: the partial result is discarded; all outputs return to 0; no done pulse is produced.
- Arithmetic is modulo 2^WIDTH. bIn = 1 subtracts one more (multi-word chaining).

Test Plan:
- Reset then idle: hold rst_n = 0 for 2 edges with start = 0 -> busy = 0, done = 0, diff = 0x0000, all flags 0. Release rst_n; start stays 0 for 20 cycles -> no change.
- Basic subtract: start with inA = 0x0005, inB = 0x0003, bIn = 0 at edge N -> busy high after edges N..N+15; done pulse after edge N+16; diff = 0x0002, bOut = 0, ovf = 0, zero = 0.
- Wrap and borrow: inA = 0x0000, inB = 0x0001, bIn = 0 -> diff = 0xFFFF, bOut = 1, ovf = 0. Then inA = 0x0005, inB = 0x0005, bIn = 0 -> diff = 0x0000, zero = 1, bOut = 0.
- Signed overflow and borrow-in:
  - inA = 0x8000, inB = 0x0001, bIn = 0 -> diff = 0x7FFF, ovf = 1, bOut = 0.
  - inA = 0x7FFF, inB = 0xFFFF, bIn = 0 -> diff = 0x8000, ovf = 1, bOut = 1.
  - inA = 0x0010, inB = 0x0001, bIn = 1 -> diff = 0x000E.
- Handshake:
  - Start accepted, then start pulsed with new operands at edges N+3 and N+8 -> ignored; result reflects the first operands only.
  - start held high during the DONE cycle with inA = 0x0009, inB = 0x0004 -> immediate new RUN; second done exactly 17 cycles after the first; diff = 0x0005.
- Reset mid-operation: rst_n = 0 at edge N+7 of a 0x1234 - 0x0034 operation -> next cycle busy = 0, diff = 0x0000, no done pulse. A fresh start then gives diff = 0x1200 after 16 cycles.
